init_i2c_sequencer: RTL

- Shares one INIT_I2C AXI-master transaction engine among N_REQ requesters, for example the per-ADC-chip init jobs.
- Round-robin arbitrates the requests and drives the engine's init trigger.
- Waits for the engine's done flag, with a timeout, and retries failed attempts.
- Returns a per-requester ack and pass/fail status. Sits between the board-init/slow-control logic and the INIT_I2C IP's INIT_AXI_TXN / TXN_DONE / ERROR pins.

---
 rtl/init_i2c_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/init_i2c_sequencer.sv
// Round-robin sequencer sharing one INIT_I2C AXI-master engine among N_REQ requesters.
// Pulses the engine trigger, waits for a fresh TXN_DONE edge (with timeout) and retries failures.
module init_i2c_sequencer #(
    parameter int N_REQ          = 4,
    parameter int INIT_PULSE_LEN = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRY      = 2,
    parameter int GAP_CYCLES     = 16,
    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] ACK,
    output logic [N_REQ-1:0] ERR_OUT,
    output logic [SEL_W-1:0] JOB_SEL,
    output logic             INIT_AXI_TXN,
    input  logic             TXN_DONE,
    input  logic             TXN_ERROR,
    output logic             BUSY,
    output logic [15:0]      ERR_COUNT
);

    localparam int CNT_MAX0 = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > INIT_PULSE_LEN) ? CNT_MAX0 : INIT_PULSE_LEN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int ATT_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_REPORT
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   job_sel_q;
    logic [ATT_W-1:0]   attempt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_dly_q;
    logic               init_txn_q;
    logic               busy_q;
    logic [N_REQ-1:0]   ack_q;
    logic [N_REQ-1:0]   err_out_q;
    logic [15:0]        err_count_q;

    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   cand;
    logic               done_edge;
    logic               timeout_hit;

    // Scan from farthest to nearest after the pointer so the nearest set bit wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = SEL_W'((int'(ptr_q) + k) % N_REQ);
            if (REQ[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // A level left high from an earlier job never completes the current one.
    assign done_edge   = TXN_DONE & ~done_dly_q;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            ptr_q       <= SEL_W'(N_REQ - 1);
            job_sel_q   <= '0;
            attempt_q   <= '0;
            cnt_q       <= '0;
            done_dly_q  <= 1'b0;
            init_txn_q  <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= '0;
            err_out_q   <= '0;
            err_count_q <= '0;
        end else begin
            done_dly_q <= TXN_DONE;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        job_sel_q  <= grant_idx;
                        ptr_q      <= grant_idx;
                        attempt_q  <= '0;
                        cnt_q      <= '0;
                        init_txn_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (cnt_q == CNT_W'(INIT_PULSE_LEN - 1)) begin
                        init_txn_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (done_edge && !TXN_ERROR) begin
                        ack_q[job_sel_q]     <= 1'b1;
                        err_out_q[job_sel_q] <= 1'b0;
                        state_q              <= S_REPORT;
                    end else if (done_edge || timeout_hit) begin
                        if (err_count_q != 16'hFFFF)
                            err_count_q <= err_count_q + 16'd1;
                        if (attempt_q < ATT_W'(MAX_RETRY)) begin
                            attempt_q <= attempt_q + 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_GAP;
                        end else begin
                            ack_q[job_sel_q]     <= 1'b1;
                            err_out_q[job_sel_q] <= 1'b1;
                            state_q              <= S_REPORT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_q      <= '0;
                        init_txn_q <= 1'b1;
                        state_q    <= S_LAUNCH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_REPORT: begin
                    ack_q     <= '0;
                    err_out_q <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ACK          = ack_q;
    assign ERR_OUT      = err_out_q;
    assign JOB_SEL      = job_sel_q;
    assign INIT_AXI_TXN = init_txn_q;
    assign BUSY         = busy_q;
    assign ERR_COUNT    = err_count_q;

endmodule
